// File: rtl/gfx_cmd_queue.sv
// Graphics command queue between the execute stage and the video unit.
// Accepts sprite/font/background commands, optionally drains only during
// vertical blank, and keeps sticky flags for overflow and bad sprite slots.
module gfx_cmd_queue #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NSPR     = 32,
  parameter int unsigned VBL_ONLY = 1,
  localparam int unsigned SEL_W   = $clog2(NSPR),
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_type,
  input  logic [4:0]       cmd_sel,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [2:0]       cmd_flags,
  input  logic             vblank,
  input  logic             out_ready,
  output logic             stall_E,
  output logic             out_valid,
  output logic [1:0]       out_type,
  output logic [SEL_W-1:0] out_sel,
  output logic [9:0]       out_x,
  output logic [8:0]       out_y,
  output logic [10:0]      out_font_addr,
  output logic [3:0]       out_font_data,
  output logic [2:0]       out_flags,
  output logic [CNT_W-1:0] count,
  output logic             err_ovf,
  output logic             err_sel
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One stored command; x/font_addr share a_lo and y/font_data share b_lo.
  typedef struct packed {
    logic [1:0]       kind;
    logic [SEL_W-1:0] sel;
    logic [10:0]      a_lo;
    logic [8:0]       b_lo;
    logic [2:0]       flags;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            full;
  logic            type_ok;
  logic            sel_ok;
  logic            pop;
  logic            push;
  logic            drop_ovf;
  logic            drop_sel;
  logic            unused_bits;

  // Operand bits above the packed fields are intentionally ignored.
  assign unused_bits = ^{cmd_a[31:11], cmd_b[31:9], cmd_sel};

  // Accept/drop decisions for the command offered this cycle.
  always_comb begin
    full     = (count == CNT_W'(DEPTH));
    type_ok  = (cmd_type != 2'b11);
    sel_ok   = (cmd_type != 2'b00) || ({1'b0, cmd_sel} < 6'(NSPR));
    pop      = out_valid && out_ready;
    push     = cmd_valid && type_ok && sel_ok && (!full || pop);
    drop_sel = cmd_valid && !sel_ok;
    drop_ovf = cmd_valid && type_ok && sel_ok && full && !pop;
  end

  // Pack the incoming command into a storage entry.
  always_comb begin
    wr_entry       = '0;
    wr_entry.kind  = cmd_type;
    wr_entry.sel   = cmd_sel[SEL_W-1:0];
    wr_entry.a_lo  = cmd_a[10:0];
    wr_entry.b_lo  = cmd_b[8:0];
    wr_entry.flags = cmd_flags;
  end

  // Storage array; contents are not reset, a reset cycle never writes.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
      err_sel <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop_ovf) err_ovf <= 1'b1;
      if (drop_sel) err_sel <= 1'b1;
    end
  end

  // Show-ahead head entry and handshake outputs.
  always_comb begin
    head          = mem[rd_ptr];
    stall_E       = full;
    out_valid     = (count != '0) && ((VBL_ONLY == 0) || vblank);
    out_type      = head.kind;
    out_sel       = head.sel;
    out_x         = head.a_lo[9:0];
    out_y         = head.b_lo;
    out_font_addr = head.a_lo;
    out_font_data = head.b_lo[3:0];
    out_flags     = head.flags;
  end

endmodule

// File: tb/tb_gfx_cmd_queue.sv
// Self-checking bench for gfx_cmd_queue (DEPTH=8, NSPR=16, VBL_ONLY=1).
module tb_gfx_cmd_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned NSPR  = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic [1:0]  cmd_type;
  logic [4:0]  cmd_sel;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [2:0]  cmd_flags;
  logic        vblank;
  logic        out_ready;
  logic        stall_E;
  logic        out_valid;
  logic [1:0]  out_type;
  logic [3:0]  out_sel;
  logic [9:0]  out_x;
  logic [8:0]  out_y;
  logic [10:0] out_font_addr;
  logic [3:0]  out_font_data;
  logic [2:0]  out_flags;
  logic [3:0]  count;
  logic        err_ovf;
  logic        err_sel;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  gfx_cmd_queue #(.DEPTH(DEPTH), .NSPR(NSPR), .VBL_ONLY(1)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_flags(cmd_flags),
    .vblank(vblank), .out_ready(out_ready), .stall_E(stall_E),
    .out_valid(out_valid), .out_type(out_type), .out_sel(out_sel),
    .out_x(out_x), .out_y(out_y), .out_font_addr(out_font_addr),
    .out_font_data(out_font_data), .out_flags(out_flags), .count(count),
    .err_ovf(err_ovf), .err_sel(err_sel)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of accepted commands plus sticky flags.
  typedef struct packed {
    logic [1:0]  t;
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
  } ent_t;

  ent_t mq[$];
  bit   m_ovf = 1'b0;
  bit   m_sel = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge from the inputs in force at that edge.
  always @(posedge clk) begin
    bit   mv;
    bit   pop;
    bit   acc;
    ent_t e;
    mv  = (mq.size() != 0) && vblank;
    pop = mv && out_ready;
    if (reset) begin
      mq.delete();
      m_ovf = 1'b0;
      m_sel = 1'b0;
    end else begin
      acc = cmd_valid && (cmd_type != 2'b11);
      if (acc && cmd_type == 2'b00 && int'(cmd_sel) >= int'(NSPR)) begin
        m_sel = 1'b1;
        acc   = 1'b0;
      end
      if (acc && mq.size() == DEPTH && !pop) begin
        m_ovf = 1'b1;
        acc   = 1'b0;
      end
      if (pop) e = mq.pop_front();
      if (acc) mq.push_back('{t: cmd_type, sel: cmd_sel, a: cmd_a, b: cmd_b, f: cmd_flags});
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    bit   mv;
    ent_t h;
    if (check_en) begin
      mv = (mq.size() != 0) && vblank;
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("stall_E", 32'(stall_E), 32'(mq.size() == DEPTH));
      chk("count", 32'(count), 32'(mq.size()));
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_sel", 32'(err_sel), 32'(m_sel));
      if (mv) begin
        h = mq[0];
        chk("out_type", 32'(out_type), 32'(h.t));
        chk("out_sel", 32'(out_sel), 32'(h.sel[3:0]));
        chk("out_x", 32'(out_x), 32'(h.a[9:0]));
        chk("out_y", 32'(out_y), 32'(h.b[8:0]));
        chk("out_font_addr", 32'(out_font_addr), 32'(h.a[10:0]));
        chk("out_font_data", 32'(out_font_data), 32'(h.b[3:0]));
        chk("out_flags", 32'(out_flags), 32'(h.f));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
    cmd_type  = 2'b00;
    cmd_sel   = 5'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    cmd_flags = 3'd0;
  endtask

  task automatic set_cmd(input logic [1:0] t, input logic [4:0] s,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_sel   = s;
    cmd_a     = a;
    cmd_b     = b;
    cmd_flags = f;
  endtask

  task automatic do_reset();
    idle();
    vblank    = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    vblank    = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    tick();
    check_en  = 1'b1;
    reset     = 1'b0;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_stall", 32'(stall_E), 32'd0);
    chk("rst_errs", 32'({err_ovf, err_sel}), 32'd0);

    // Three sprites held off by vblank, then drained in order.
    for (int i = 1; i <= 3; i++) begin
      set_cmd(2'b00, 5'(i), 32'(i * 7), 32'(i * 3), 3'(i));
      tick();
    end
    idle();
    chk("hold_count", 32'(count), 32'd3);
    chk("hold_valid", 32'(out_valid), 32'd0);
    vblank    = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("drain_sel1", 32'(out_sel), 32'd1);
    tick();
    chk("drain_sel2", 32'(out_sel), 32'd2);
    tick();
    chk("drain_sel3", 32'(out_sel), 32'd3);
    tick();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Fill to full, overflow drop, then push accepted alongside a pop.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_cmd(2'b01, 5'(i), 32'(100 + i), 32'(i), 3'd0);
      tick();
    end
    chk("full_stall", 32'(stall_E), 32'd1);
    chk("full_count", 32'(count), 32'd8);
    set_cmd(2'b01, 5'd9, 32'd900, 32'd9, 3'd1);
    tick();
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd8);
    vblank    = 1'b1;
    out_ready = 1'b1;
    set_cmd(2'b01, 5'd10, 32'd901, 32'd10, 3'd2);
    tick();
    idle();
    out_ready = 1'b0;
    chk("pushpop_count", 32'(count), 32'd8);
    chk("pushpop_ovf", 32'(err_ovf), 32'd1);
    chk("pushpop_head", 32'(out_font_addr), 32'd101);

    // Sprite slot beyond NSPR is rejected, font with same sel is kept.
    do_reset();
    set_cmd(2'b00, 5'd20, 32'd1, 32'd1, 3'd0);
    tick();
    chk("badsel_flag", 32'(err_sel), 32'd1);
    chk("badsel_count", 32'(count), 32'd0);
    set_cmd(2'b01, 5'd20, 32'd1, 32'd1, 3'd0);
    tick();
    idle();
    chk("fontsel_count", 32'(count), 32'd1);
    set_cmd(2'b11, 5'd0, 32'd0, 32'd0, 3'd0);
    tick();
    idle();
    chk("reserved_count", 32'(count), 32'd1);

    // Field packing for font and sprite commands.
    do_reset();
    vblank = 1'b1;
    set_cmd(2'b01, 5'd0, 32'h3FF, 32'h1FF, 3'b101);
    tick();
    idle();
    chk("font_addr", 32'(out_font_addr), 32'h3FF);
    chk("font_data", 32'(out_font_data), 32'hF);
    out_ready = 1'b1;
    set_cmd(2'b00, 5'd5, 32'h3FF, 32'h1FF, 3'b010);
    tick();
    idle();
    out_ready = 1'b0;
    chk("spr_x", 32'(out_x), 32'h3FF);
    chk("spr_y", 32'(out_y), 32'h1FF);
    chk("spr_flags", 32'(out_flags), 32'h2);

    // vblank drops mid-drain, then reset wins over a push.
    do_reset();
    set_cmd(2'b00, 5'd17, 32'd0, 32'd0, 3'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_cmd(2'b10, 5'(i), 32'(i), 32'(i), 3'd0);
      tick();
    end
    idle();
    chk("mid_count5", 32'(count), 32'd5);
    vblank    = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    #1;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_count3", 32'(count), 32'd3);
    reset = 1'b1;
    set_cmd(2'b01, 5'd1, 32'd5, 32'd5, 3'd0);
    tick();
    reset = 1'b0;
    idle();
    chk("rstpush_count", 32'(count), 32'd0);
    chk("rstpush_errs", 32'({err_ovf, err_sel}), 32'd0);

    // Streaming push+pop across several pointer wraps.
    do_reset();
    vblank = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_cmd(2'b01, 5'd0, 32'(i), 32'(i), 3'd0);
      tick();
    end
    out_ready = 1'b1;
    for (int i = 4; i < 4 + 3 * int'(DEPTH); i++) begin
      set_cmd(2'b01, 5'd0, 32'(i), 32'(i), 3'd0);
      tick();
      chk("stream_count", 32'(count), 32'd4);
    end
    idle();

    // Randomized traffic with phases biased toward filling or draining.
    do_reset();
    for (int ph = 0; ph < 10; ph++) begin
      for (int c = 0; c < 200; c++) begin
        cmd_valid = ($urandom_range(0, 3) != 0);
        cmd_type  = 2'($urandom_range(0, 3));
        cmd_sel   = 5'($urandom_range(0, 31));
        cmd_a     = $urandom;
        cmd_b     = $urandom;
        cmd_flags = 3'($urandom_range(0, 7));
        vblank    = ($urandom_range(0, 3) != 0);
        out_ready = (ph % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                  : ($urandom_range(0, 3) != 0);
        reset     = ($urandom_range(0, 299) == 0);
        tick();
      end
    end
    reset = 1'b0;
    idle();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gfx_cmd_queue.md
GFX_CMD_QUEUE -- requirements
Module: gfx_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 8: queue entries; power of two, 2..64.
REQ-002 Parameter NSPR, default 32: sprite slots addressable; 2..32; SEL_W = clog2(NSPR).
REQ-003 Parameter VBL_ONLY, default 1: 1 = drain only while vblank high; 0 = drain whenever non-empty.
REQ-004 Clock and reset SHALL be named clk and reset; one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 cmd_valid  in  1  push request from execute stage.
REQ-008 cmd_type  in  2  00 sprite, 01 font, 10 background, 11 reserved.
REQ-009 cmd_sel  in  5  sprite slot (rd field).
REQ-010 cmd_a / cmd_b  in  32 each  forwarded source operands.
REQ-011 cmd_flags  in  3  {pos, attr, visi}.
REQ-012 vblank  in  1  vertical-blank window from video timing.
REQ-013 out_ready  in  1  video unit accepts head entry.
REQ-014 stall_E  out  1  queue full; execute stage holds.
REQ-015 out_valid  out  1  head entry presented.
REQ-016 out_type  out  2; out_sel  out  SEL_W; out_x  out  10; out_y  out  9; out_font_addr  out  11; out_font_data  out  4; out_flags  out  3  head entry fields.
REQ-017 count  out  clog2(DEPTH)+1  current occupancy.
REQ-018 err_ovf / err_sel  out  1 each  sticky overflow / bad-slot flags.

Function
REQ-019 Entry packing SHALL be: x = cmd_a[9:0], y = cmd_b[8:0], font_addr = cmd_a[10:0], font_data = cmd_b[3:0], sel = cmd_sel[SEL_W-1:0], type, flags; unused fields stored as captured.
REQ-020 Push occurs on a clk edge when cmd_valid=1, type!=11, cmd_sel<NSPR (sprite type only), and (count<DEPTH or pop same cycle).
REQ-021 cmd_type=11 SHALL be silently discarded, no flag.
REQ-022 Sprite command with cmd_sel>=NSPR SHALL be discarded and set err_sel.
REQ-023 Push while full without simultaneous pop SHALL be discarded and set err_ovf.
REQ-024 err_ovf and err_sel clear only on reset.
REQ-025 stall_E = (count==DEPTH), combinational from registered count.
REQ-026 out_valid = (count!=0) and (VBL_ONLY==0 or vblank==1); head fields show-ahead from storage, stable while out_valid and not out_ready.
REQ-027 Pop occurs on a clk edge when out_valid=1 and out_ready=1.
REQ-028 Push-to-out_valid latency: 1 cycle minimum (pushed edge N, visible after edge N, i.e. cycle N+1).
REQ-029 Simultaneous push and pop: count unchanged, both pointers advance, FIFO order preserved.
REQ-030 Pointers SHALL wrap modulo DEPTH; count saturates neither above DEPTH nor below 0.
REQ-031 vblank falling mid-drain: out_valid drops same cycle; remaining entries held, order preserved.
REQ-032 out_* fields other than out_valid are don't-care when out_valid=0.

Reset
REQ-033 On reset: count=0, read/write pointers=0, err_ovf=0, err_sel=0, stall_E=0, out_valid=0.
REQ-034 Reset has priority over push and pop in the same cycle; queued entries lost.
REQ-035 Storage array contents need not be reset.

Verification
REQ-036 VBL_ONLY=1, vblank=0: push 3 sprite cmds (sel 1,2,3) -> count=3, out_valid=0; raise vblank, out_ready=1 -> sel 1,2,3 in order on 3 edges, count=0.
REQ-037 DEPTH=8: push 8 cmds -> stall_E=1; 9th push with no pop -> dropped, err_ovf=1, count=8; 9th push with pop same edge -> accepted, count=8, err_ovf unchanged.
REQ-038 NSPR=16: sprite push with cmd_sel=20 -> not queued, err_sel=1; font push same sel -> queued.
REQ-039 cmd_a=0x3FF, cmd_b=0x1FF, font type -> out_font_addr=0x3FF, out_font_data=0xF; sprite type -> out_x=0x3FF, out_y=0x1FF.
REQ-040 count=5, vblank toggles low after 2 pops -> out_valid=0, count=3; reset asserted with push -> count=0, err flags 0 next cycle.
REQ-041 Continuous push+pop for 3*DEPTH cycles -> pointer wrap, count constant, output order equals input order.
